// File: rtl/flag_unit.sv
// rtl/flag_unit.sv - processor flag register with compare, load, interrupt mask and save stack
//
// Purpose:
//   Holds a WIDTH-bit flag word.
//   Bit 0 is EQ, bit 1 is GT, bit 2 is IM (interrupt mask) and bit 3 is LT.
//   Bits WIDTH-1:4 are general purpose.
//   The flag word can be set from a compare of bus1/bus2, loaded from bus1,
//   or restored from a LIFO save stack of STACK_DEPTH entries.
//   All outputs are registered.
//
// Configuration:
//   FLAG_UNIT_SIGNED_CMP_EN - when defined, signed_cmp=1 selects two's-complement
//   ordering for GT/LT. When undefined, signed_cmp is ignored and compares are unsigned.
//
// Ports:
//   clk          in   sole clock, rising edge
//   rst          in   synchronous active-high reset
//   compare      in   load EQ/GT/LT from bus1 vs bus2
//   signed_cmp   in   two's-complement compare select
//   load         in   load all flag bits from bus1
//   mask_int     in   force IM=1 after source selection
//   unmask_int   in   force IM=0 after source selection (mask_int wins)
//   push         in   save current flags onto the stack
//   pop          in   restore flags from the stack top
//   bus1, bus2   in   WIDTH-bit operands; bus1 is also the load source
//   flags        out  registered flag word
//   stack_empty  out  registered stack empty status
//   stack_full   out  registered stack full status
//   stack_err    out  sticky misuse flag, cleared only by rst

module flag_unit #(
   parameter int WIDTH       = 16,
   parameter int STACK_DEPTH = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             compare,
   input  logic             signed_cmp,
   input  logic             load,
   input  logic             mask_int,
   input  logic             unmask_int,
   input  logic             push,
   input  logic             pop,
   input  logic [WIDTH-1:0] bus1,
   input  logic [WIDTH-1:0] bus2,
   output logic [WIDTH-1:0] flags,
   output logic             stack_empty,
   output logic             stack_full,
   output logic             stack_err
);

   localparam int CW = $clog2(STACK_DEPTH + 1);
   localparam logic [WIDTH-1:0] FLAGS_RST = {{(WIDTH-3){1'b0}}, 3'b100};

   logic [WIDTH-1:0] flags_q, flags_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic             empty_q, empty_d;
   logic             full_q, full_d;
   logic             err_q, err_d;
   logic [WIDTH-1:0] stack_q [STACK_DEPTH];
   logic [WIDTH-1:0] stack_d [STACK_DEPTH];

   logic             push_ok;
   logic             pop_ok;
   logic             misuse;
   logic [WIDTH-1:0] top_word;
   logic             cmp_eq;
   logic             cmp_gt;
   logic             cmp_lt;
   logic [WIDTH-1:0] cmp_word;

   // Compare results
   always_comb begin
      cmp_eq = (bus1 == bus2);
      cmp_gt = (bus1 > bus2);
`ifdef FLAG_UNIT_SIGNED_CMP_EN
      if (signed_cmp) begin
         cmp_gt = ($signed(bus1) > $signed(bus2));
      end
`endif
      // Exactly one of EQ/GT/LT is set.
      cmp_lt = ~cmp_eq & ~cmp_gt;
   end

`ifndef FLAG_UNIT_SIGNED_CMP_EN
   logic unused_signed_cmp;
   assign unused_signed_cmp = signed_cmp;
`endif

   // Stack control.
   // A simultaneous push and pop is treated as misuse and neither takes effect.
   always_comb begin
      push_ok = push & ~pop & ~full_q;
      pop_ok  = pop & ~push & ~empty_q;
      misuse  = (push & pop) | (push & ~pop & full_q) | (pop & ~push & empty_q);
   end

   // The top entry lives at index cnt_q-1.
   // The loop form keeps the index width matched to the array.
   always_comb begin
      top_word = '0;
      for (int i = 0; i < STACK_DEPTH; i++) begin
         if (cnt_q == CW'(i + 1)) begin
            top_word = stack_q[i];
         end
      end
   end

   // Push stores the pre-edge flag word into the next free slot.
   always_comb begin
      for (int i = 0; i < STACK_DEPTH; i++) begin
         stack_d[i] = stack_q[i];
         if (push_ok && (cnt_q == CW'(i))) begin
            stack_d[i] = flags_q;
         end
      end
   end

   // Flag source selection, then the interrupt-mask override.
   always_comb begin
      cmp_word    = flags_q;
      cmp_word[0] = cmp_eq;
      cmp_word[1] = cmp_gt;
      cmp_word[3] = cmp_lt;

      if (load) begin
         flags_d = bus1;
      end else if (pop_ok) begin
         flags_d = top_word;
      end else if (compare) begin
         flags_d = cmp_word;
      end else begin
         flags_d = flags_q;
      end

      if (mask_int) begin
         flags_d[2] = 1'b1;
      end else if (unmask_int) begin
         flags_d[2] = 1'b0;
      end
   end

   // Occupancy and status
   always_comb begin
      cnt_d = cnt_q;
      if (push_ok) begin
         cnt_d = cnt_q + CW'(1);
      end else if (pop_ok) begin
         cnt_d = cnt_q - CW'(1);
      end
      empty_d = (cnt_d == '0);
      full_d  = (cnt_d == CW'(STACK_DEPTH));
      err_d   = err_q | misuse;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         flags_q <= FLAGS_RST;
         cnt_q   <= '0;
         empty_q <= 1'b1;
         full_q  <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         flags_q <= flags_d;
         cnt_q   <= cnt_d;
         empty_q <= empty_d;
         full_q  <= full_d;
         err_q   <= err_d;
      end
   end

   // Stack contents are not cleared by reset.
   // The count alone defines which entries are valid.
   always_ff @(posedge clk) begin
      if (!rst) begin
         for (int i = 0; i < STACK_DEPTH; i++) begin
            stack_q[i] <= stack_d[i];
         end
      end
   end

   assign flags       = flags_q;
   assign stack_empty = empty_q;
   assign stack_full  = full_q;
   assign stack_err   = err_q;

endmodule

// File: tb/tb_flag_unit.sv
// tb/tb_flag_unit.sv - self-checking bench for flag_unit with a queue-based reference model

module tb_flag_unit;

   localparam int W = 16;
   localparam int D = 4;

   logic          clk = 1'b0;
   logic          rst, compare, signed_cmp, load, mask_int, unmask_int, push, pop;
   logic [W-1:0]  bus1, bus2;
   logic [W-1:0]  flags;
   logic          stack_empty, stack_full, stack_err;

   int checks = 0;
   int errors = 0;

   // Reference model state
   logic [W-1:0] m_flags;
   logic [W-1:0] m_stack[$];
   logic         m_err;

   flag_unit #(.WIDTH(W), .STACK_DEPTH(D)) dut (
      .clk(clk), .rst(rst), .compare(compare), .signed_cmp(signed_cmp),
      .load(load), .mask_int(mask_int), .unmask_int(unmask_int),
      .push(push), .pop(pop), .bus1(bus1), .bus2(bus2),
      .flags(flags), .stack_empty(stack_empty), .stack_full(stack_full),
      .stack_err(stack_err)
   );

   always #5 clk = ~clk;

   function automatic int to_int(input logic [W-1:0] v, input logic as_signed);
      if (as_signed && v[W-1]) return int'(v) - (1 << W);
      return int'(v);
   endfunction

   task automatic model_apply(input logic r, c, s, l, m, u, pu, po,
                              input logic [W-1:0] b1, b2);
      logic [W-1:0] nf;
      logic [W-1:0] top;
      logic         pop_valid;
      logic         sgn;
      int           a, b;
      if (r) begin
         m_flags = 16'h0004;
         m_stack.delete();
         m_err = 1'b0;
         return;
      end
      nf = m_flags;
      top = '0;
      pop_valid = 1'b0;
      if (pu && po) begin
         m_err = 1'b1;
      end else if (pu) begin
         if (m_stack.size() == D) m_err = 1'b1;
         else m_stack.push_back(m_flags);
      end else if (po) begin
         if (m_stack.size() == 0) m_err = 1'b1;
         else begin
            top = m_stack.pop_back();
            pop_valid = 1'b1;
         end
      end
`ifdef FLAG_UNIT_SIGNED_CMP_EN
      sgn = s;
`else
      sgn = 1'b0;
`endif
      if (l) nf = b1;
      else if (pop_valid) nf = top;
      else if (c) begin
         a = to_int(b1, sgn);
         b = to_int(b2, sgn);
         nf[0] = (a == b);
         nf[1] = (a > b);
         nf[3] = (a < b);
      end
      if (m) nf[2] = 1'b1;
      else if (u) nf[2] = 1'b0;
      m_flags = nf;
   endtask

   // Drive one cycle of inputs, sample after the edge, advance the model.
   task automatic drive(input logic r, c, s, l, m, u, pu, po,
                        input logic [W-1:0] b1, b2);
      @(negedge clk);
      rst = r; compare = c; signed_cmp = s; load = l;
      mask_int = m; unmask_int = u; push = pu; pop = po;
      bus1 = b1; bus2 = b2;
      @(posedge clk);
      #1;
      rst = 0; compare = 0; signed_cmp = 0; load = 0;
      mask_int = 0; unmask_int = 0; push = 0; pop = 0;
      model_apply(r, c, s, l, m, u, pu, po, b1, b2);
   endtask

   task automatic do_reset();
      drive(1, 0, 0, 0, 0, 0, 0, 0, '0, '0);
   endtask

   task automatic test_reset();
      // Reset must win over a concurrent push/pop/load.
      drive(1, 1, 0, 1, 0, 1, 1, 1, 16'hABCD, 16'h1234);
      checks++;
      if (flags !== 16'h0004) begin
         errors++; $display("FAIL reset_flags got %h exp %h", flags, 16'h0004);
      end
      checks++;
      if ({stack_empty, stack_full, stack_err} !== 3'b100) begin
         errors++; $display("FAIL reset_status got %b exp %b", {stack_empty, stack_full, stack_err}, 3'b100);
      end
   endtask

   task automatic test_compare();
      do_reset();
      drive(0, 1, 0, 0, 0, 0, 0, 0, 16'h0005, 16'h0005);
      checks++;
      if (flags !== 16'h0005) begin
         errors++; $display("FAIL cmp_eq got %h exp %h", flags, 16'h0005);
      end
      drive(0, 1, 1, 0, 0, 0, 0, 0, 16'hFFFF, 16'h0001);
      checks++;
`ifdef FLAG_UNIT_SIGNED_CMP_EN
      if (flags !== 16'h000C) begin
         errors++; $display("FAIL cmp_signed got %h exp %h", flags, 16'h000C);
      end
`else
      if (flags !== 16'h0006) begin
         errors++; $display("FAIL cmp_signed_ignored got %h exp %h", flags, 16'h0006);
      end
`endif
      drive(0, 1, 0, 0, 0, 0, 0, 0, 16'hFFFF, 16'h0001);
      checks++;
      if (flags !== 16'h0006) begin
         errors++; $display("FAIL cmp_unsigned got %h exp %h", flags, 16'h0006);
      end
      // Compare keeps the general-purpose bits.
      drive(0, 0, 0, 1, 0, 0, 0, 0, 16'hA5F0, '0);
      drive(0, 1, 0, 0, 0, 0, 0, 0, 16'h0002, 16'h0009);
      checks++;
      if (flags !== 16'hA5F8) begin
         errors++; $display("FAIL cmp_hold_gp got %h exp %h", flags, 16'hA5F8);
      end
   endtask

   task automatic test_push_pop();
      do_reset();
      drive(0, 0, 0, 1, 0, 0, 0, 0, 16'h00F0, '0);
      drive(0, 0, 0, 0, 1, 0, 1, 0, '0, '0);
      checks++;
      if (flags !== 16'h00F4 || stack_empty !== 1'b0) begin
         errors++; $display("FAIL push_mask got %h/%b exp %h/0", flags, stack_empty, 16'h00F4);
      end
      drive(0, 0, 0, 1, 0, 0, 0, 0, 16'h0000, '0);
      drive(0, 0, 0, 0, 0, 0, 0, 1, '0, '0);
      checks++;
      if (flags !== 16'h00F0 || stack_empty !== 1'b1 || stack_err !== 1'b0) begin
         errors++; $display("FAIL pop_restore got %h/%b/%b exp %h/1/0", flags, stack_empty, stack_err, 16'h00F0);
      end
      // Pop with load: the entry is consumed and load decides the flags.
      drive(0, 0, 0, 0, 0, 0, 1, 0, '0, '0);
      drive(0, 0, 0, 1, 0, 0, 0, 1, 16'h1230, '0);
      checks++;
      if (flags !== 16'h1230 || stack_empty !== 1'b1) begin
         errors++; $display("FAIL pop_load got %h/%b exp %h/1", flags, stack_empty, 16'h1230);
      end
      // Push and pop together are both ignored and flag an error.
      drive(0, 0, 0, 0, 0, 0, 1, 1, '0, '0);
      checks++;
      if (stack_empty !== 1'b1 || stack_err !== 1'b1 || flags !== 16'h1230) begin
         errors++; $display("FAIL push_pop_same got %b/%b/%h exp 1/1/%h", stack_empty, stack_err, flags, 16'h1230);
      end
   endtask

   task automatic test_overflow();
      logic [W-1:0] v;
      do_reset();
      for (int i = 0; i < 5; i++) begin
         v = 16'h0100 * W'(i + 1);
         drive(0, 0, 0, 1, 0, 0, 0, 0, v, '0);
         drive(0, 0, 0, 0, 0, 0, 1, 0, '0, '0);
         if (i == 3) begin
            checks++;
            if (stack_full !== 1'b1 || stack_err !== 1'b0) begin
               errors++; $display("FAIL full_after_4 got %b/%b exp 1/0", stack_full, stack_err);
            end
         end
      end
      checks++;
      if (stack_full !== 1'b1 || stack_err !== 1'b1) begin
         errors++; $display("FAIL err_after_5 got %b/%b exp 1/1", stack_full, stack_err);
      end
      for (int i = 3; i >= 0; i--) begin
         drive(0, 0, 0, 0, 0, 0, 0, 1, '0, '0);
         v = 16'h0100 * W'(i + 1);
         checks++;
         if (flags !== v) begin
            errors++; $display("FAIL lifo_pop%0d got %h exp %h", i, flags, v);
         end
      end
      checks++;
      if (stack_empty !== 1'b1 || stack_full !== 1'b0) begin
         errors++; $display("FAIL drained got %b/%b exp 1/0", stack_empty, stack_full);
      end
   endtask

   task automatic test_pop_empty();
      do_reset();
      drive(0, 1, 0, 0, 0, 0, 0, 1, 16'd3, 16'd7);
      checks++;
      if (flags !== 16'h000C || stack_err !== 1'b1 || stack_empty !== 1'b1) begin
         errors++; $display("FAIL pop_empty got %h/%b/%b exp %h/1/1", flags, stack_err, stack_empty, 16'h000C);
      end
      // A following push must land in slot 0, proving the count stayed 0.
      drive(0, 0, 0, 0, 0, 0, 1, 0, '0, '0);
      drive(0, 0, 0, 0, 0, 0, 0, 1, '0, '0);
      checks++;
      if (stack_empty !== 1'b1 || flags !== 16'h000C) begin
         errors++; $display("FAIL count_stayed got %b/%h exp 1/%h", stack_empty, flags, 16'h000C);
      end
   endtask

   task automatic test_mask_both();
      do_reset();
      drive(0, 0, 0, 1, 1, 1, 0, 0, 16'h0000, '0);
      checks++;
      if (flags !== 16'h0004) begin
         errors++; $display("FAIL mask_wins got %h exp %h", flags, 16'h0004);
      end
      drive(0, 0, 0, 0, 0, 1, 0, 0, '0, '0);
      checks++;
      if (flags !== 16'h0000) begin
         errors++; $display("FAIL unmask got %h exp %h", flags, 16'h0000);
      end
   endtask

   task automatic test_random();
      logic [W-1:0] b1, b2;
      for (int n = 0; n < 400; n++) begin
         b1 = W'($urandom);
         b2 = ($urandom_range(0, 3) == 0) ? b1 : W'($urandom);
         drive(($urandom_range(0, 59) == 0),
               ($urandom_range(0, 1) == 0),
               ($urandom_range(0, 1) == 0),
               ($urandom_range(0, 5) == 0),
               ($urandom_range(0, 5) == 0),
               ($urandom_range(0, 5) == 0),
               ($urandom_range(0, 2) == 0),
               ($urandom_range(0, 2) == 0),
               b1, b2);
         checks++;
         if (flags !== m_flags || stack_empty !== (m_stack.size() == 0) ||
             stack_full !== (m_stack.size() == D) || stack_err !== m_err) begin
            errors++;
            $display("FAIL random_%0d got %h/%b/%b/%b exp %h/%b/%b/%b", n,
                     flags, stack_empty, stack_full, stack_err,
                     m_flags, (m_stack.size() == 0), (m_stack.size() == D), m_err);
         end
      end
   endtask

   initial begin
      rst = 1; compare = 0; signed_cmp = 0; load = 0;
      mask_int = 0; unmask_int = 0; push = 0; pop = 0;
      bus1 = '0; bus2 = '0;
      m_flags = 16'h0004; m_err = 1'b0;
      test_reset();
      test_compare();
      test_push_pop();
      test_overflow();
      test_pop_empty();
      test_mask_both();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/flag_unit.md
FLAG_UNIT -- requirements
Module: flag_unit

Interface
REQ-001 SHALL have parameter WIDTH, default 16, the flag word and operand width (minimum 4).
REQ-002 SHALL have parameter STACK_DEPTH, default 4, the number of flag words the save stack holds (minimum 1).
REQ-003 SHALL have port clk  input  1  sole clock; all state changes on its rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port compare  input  1  load compare results into flags.
REQ-006 SHALL have port signed_cmp  input  1  select two's-complement compare (see Configuration).
REQ-007 SHALL have port load  input  1  load flags from bus1.
REQ-008 SHALL have port mask_int  input  1  set interrupt-mask flag.
REQ-009 SHALL have port unmask_int  input  1  clear interrupt-mask flag.
REQ-010 SHALL have port push  input  1  save current flags onto the stack.
REQ-011 SHALL have port pop  input  1  restore flags from the stack top.
REQ-012 SHALL have ports bus1, bus2  input  WIDTH  operands; bus1 also the load source.
REQ-013 SHALL have port flags  output  WIDTH  registered flag word.
REQ-014 SHALL have ports stack_empty, stack_full  output  1  registered stack occupancy status.
REQ-015 SHALL have port stack_err  output  1  sticky stack misuse indicator.

Function
REQ-016 Flag layout SHALL be: bit0 EQ (bus1==bus2), bit1 GT (bus1>bus2), bit2 IM (interrupt mask), bit3 LT (bus1<bus2), bits WIDTH-1:4 general purpose.
REQ-017 All outputs SHALL be registered; every update SHALL be visible one cycle after the qualifying edge.
REQ-018 Flag source priority SHALL be load > pop (valid) > compare > hold.
REQ-019 Compare SHALL update only bits 0,1,3; bits 2 and WIDTH-1:4 SHALL hold; exactly one of EQ/GT/LT SHALL be 1.
REQ-020 Load SHALL copy bus1 to all WIDTH bits; pop SHALL copy the stack-top word to all WIDTH bits.
REQ-021 After source selection, mask_int SHALL force bit2=1, else unmask_int SHALL force bit2=0; mask_int wins if both are asserted.
REQ-022 Push SHALL store the flags value present before the edge, so push+mask_int saves the unmasked state and masks in one cycle.
REQ-023 Stack SHALL be LIFO; occupancy count SHALL range 0..STACK_DEPTH with no wrap-around.
REQ-024 Push when full SHALL be ignored (no write, count unchanged) and SHALL set stack_err.
REQ-025 Pop when empty SHALL be ignored (flags unchanged by pop; lower-priority compare still applies) and SHALL set stack_err.
REQ-026 Push and pop in the same cycle SHALL both be ignored and SHALL set stack_err.
REQ-027 Pop together with load SHALL still remove the top entry; load SHALL determine flags.
REQ-028 stack_err SHALL clear only on rst.

Reset
REQ-029 On rst, flags SHALL become 0x...0004 (only IM set), stack count 0, stack_empty=1, stack_full=0, stack_err=0.
REQ-030 rst SHALL override all other inputs in the same cycle, including a push/pop in progress; stack contents need not be cleared.

Configuration
REQ-031 With macro FLAG_UNIT_SIGNED_CMP_EN defined, signed_cmp=1 SHALL make GT/LT use two's-complement ordering; signed_cmp=0 SHALL use unsigned ordering.
REQ-032 Without FLAG_UNIT_SIGNED_CMP_EN, the signed_cmp port SHALL remain but be ignored and all compares SHALL be unsigned.

Verification
REQ-033 rst, then compare bus1=0x0005 bus2=0x0005 -> flags=0x0005 (EQ, IM).
REQ-034 Macro defined, compare signed_cmp=1 bus1=0xFFFF bus2=0x0001 -> LT=1, GT=0; signed_cmp=0 same operands -> GT=1, LT=0.
REQ-035 load bus1=0x00F0, then push+mask_int -> flags=0x00F4; load 0x0000, then pop -> flags=0x00F0, stack_empty=1.
REQ-036 Five pushes with STACK_DEPTH=4 -> stack_full=1 after 4th, stack_err=1 after 5th; four pops return values in reverse order.
REQ-037 pop when empty together with compare bus1=3 bus2=7 -> LT=1, stack_err=1, count stays 0.
REQ-038 load bus1=0x0000 with mask_int=1 and unmask_int=1 -> flags=0x0004.
